nfc_ecc_seq: RTL and testbench

//  Per-sector ECC sequencer in the clk_2x domain of the NAND flash controller.

---
 rtl/nfc_ecc_pkg.sv | 20 ++
 rtl/nfc_ecc_wdog.sv | 36 +++
 rtl/nfc_ecc_seq.sv | 241 ++++++++++++++++++++++++
 tb/tb_nfc_ecc_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nfc_ecc_pkg.sv
// Shared constants and state encoding for the per-sector ECC sequencer.
package nfc_ecc_pkg;

    localparam int unsigned ECC_DWID = 8;
    localparam int unsigned ECC_AWID = 9;
    localparam int unsigned SECT_LEN = 512;
    localparam int unsigned PAR_LEN  = 14;
    localparam int unsigned MAX_ERR  = 8;
    localparam int unsigned TMO_CYC  = 1023;

    typedef enum logic [2:0] {
        StIdle,
        StFeed,
        StCalc,
        StParOut,
        StLocOut,
        StDone
    } seq_state_e;

endpackage

// File: rtl/nfc_ecc_wdog.sv
// Loadable down-counter watchdog: expire pulses on the TMO_CYC-th consecutive enabled,
// unloaded cycle.
module nfc_ecc_wdog #(
    parameter int unsigned TMO_CYC = 1023
) (
    input  logic clk_2x,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(TMO_CYC + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CntW'(TMO_CYC);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign expire_o = en_i && !load_i && (cnt_q == CntW'(1));

    always_ff @(posedge clk_2x or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CntW'(TMO_CYC);
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nfc_ecc_seq.sv
// Per-sector ECC sequencer: streams sector bytes into the BCH engine and forwards parity
// bytes or error locations into the correction bridge FIFO.
module nfc_ecc_seq
    import nfc_ecc_pkg::*;
(
    input  logic                clk_2x,
    input  logic                rst_n,
    input  logic                seq_start,
    input  logic                seq_dir,
    input  logic                seq_abort,
    input  logic                nfc_byte_vld,
    input  logic [ECC_DWID-1:0] nfc_byte,
    output logic                eng_start,
    output logic                eng_mode,
    output logic                eng_din_vld,
    output logic [ECC_DWID-1:0] eng_din,
    output logic                eng_din_last,
    input  logic                eng_par_vld,
    input  logic [ECC_DWID-1:0] eng_par,
    input  logic                eng_err_vld,
    input  logic [ECC_AWID-1:0] eng_err_addr,
    input  logic                eng_dec_done,
    input  logic                eng_fail,
    output logic                ecc_fifo_wr,
    output logic [ECC_DWID-1:0] ecc_enc_dat,
    output logic [ECC_AWID-1:0] ecc_dec_addr,
    output logic                ecc_done,
    output logic                seq_busy,
    output logic [4:0]          seq_err_cnt,
    output logic                seq_uncor,
    output logic                seq_timeout
);

    seq_state_e          state_q, state_d;
    logic [ECC_AWID-1:0] byte_cnt_q, byte_cnt_d;
    logic [5:0]          par_cnt_q, par_cnt_d;
    logic [4:0]          err_cnt_q, err_cnt_d;
    logic                eng_start_q, eng_start_d;
    logic                eng_mode_q, eng_mode_d;
    logic                din_vld_q, din_vld_d;
    logic [ECC_DWID-1:0] din_q, din_d;
    logic                din_last_q, din_last_d;
    logic                fifo_wr_q, fifo_wr_d;
    logic [ECC_DWID-1:0] enc_dat_q, enc_dat_d;
    logic [ECC_AWID-1:0] dec_addr_q, dec_addr_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                uncor_q, uncor_d;
    logic                timeout_q, timeout_d;

    logic watched, eng_act, wd_expire;

    assign watched = (state_q == StCalc) || (state_q == StParOut) || (state_q == StLocOut);
    assign eng_act = eng_par_vld || eng_err_vld || eng_dec_done || eng_fail;

    nfc_ecc_wdog #(
        .TMO_CYC(TMO_CYC)
    ) u_wdog (
        .clk_2x  (clk_2x),
        .rst_n   (rst_n),
        .load_i  (!watched || eng_act),
        .en_i    (watched),
        .expire_o(wd_expire)
    );

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        par_cnt_d   = par_cnt_q;
        err_cnt_d   = err_cnt_q;
        eng_start_d = 1'b0;
        eng_mode_d  = eng_mode_q;
        din_vld_d   = 1'b0;
        din_d       = din_q;
        din_last_d  = 1'b0;
        fifo_wr_d   = 1'b0;
        enc_dat_d   = enc_dat_q;
        dec_addr_d  = dec_addr_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        uncor_d     = uncor_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (seq_start && !seq_abort) begin
                    state_d     = StFeed;
                    eng_start_d = 1'b1;
                    eng_mode_d  = seq_dir;
                    byte_cnt_d  = '0;
                    par_cnt_d   = '0;
                    err_cnt_d   = '0;
                    uncor_d     = 1'b0;
                    timeout_d   = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            StFeed: begin
                if (seq_abort) begin
                    state_d = StDone;
                end else if (nfc_byte_vld) begin
                    din_vld_d  = 1'b1;
                    din_d      = nfc_byte;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == ECC_AWID'(SECT_LEN - 1)) begin
                        din_last_d = 1'b1;
                        byte_cnt_d = '0;
                        state_d    = StCalc;
                    end
                end
            end
            StCalc: begin
                if (seq_abort) begin
                    state_d = StDone;
                end else if (eng_mode_q) begin
                    if (eng_par_vld) begin
                        fifo_wr_d = 1'b1;
                        enc_dat_d = eng_par;
                        par_cnt_d = 6'd1;
                        state_d   = StParOut;
                    end else if (wd_expire) begin
                        timeout_d = 1'b1;
                        state_d   = StDone;
                    end
                end else if (eng_fail) begin
                    uncor_d = 1'b1;
                    state_d = StDone;
                end else if (eng_err_vld) begin
                    fifo_wr_d  = 1'b1;
                    dec_addr_d = eng_err_addr;
                    err_cnt_d  = 5'd1;
                    state_d    = eng_dec_done ? StDone : StLocOut;
                end else if (eng_dec_done) begin
                    state_d = StDone;
                end else if (wd_expire) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end
            end
            StParOut: begin
                if (seq_abort) begin
                    state_d = StDone;
                end else if (eng_par_vld) begin
                    fifo_wr_d = 1'b1;
                    enc_dat_d = eng_par;
                    par_cnt_d = par_cnt_q + 1'b1;
                    if (par_cnt_q == 6'(PAR_LEN - 1)) begin
                        state_d = StDone;
                    end
                end else if (wd_expire) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end
            end
            StLocOut: begin
                if (seq_abort) begin
                    state_d = StDone;
                end else if (eng_fail) begin
                    uncor_d = 1'b1;
                    state_d = StDone;
                end else begin
                    // Beyond MAX_ERR the bridge FIFO is full: flag uncorrectable, keep draining.
                    if (eng_err_vld) begin
                        if (err_cnt_q < 5'(MAX_ERR)) begin
                            fifo_wr_d  = 1'b1;
                            dec_addr_d = eng_err_addr;
                            err_cnt_d  = err_cnt_q + 1'b1;
                        end else begin
                            uncor_d = 1'b1;
                        end
                    end
                    if (eng_dec_done) begin
                        state_d = StDone;
                    end else if (wd_expire) begin
                        timeout_d = 1'b1;
                        state_d   = StDone;
                    end
                end
            end
            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_2x or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            byte_cnt_q  <= '0;
            par_cnt_q   <= '0;
            err_cnt_q   <= '0;
            eng_start_q <= 1'b0;
            eng_mode_q  <= 1'b1;
            din_vld_q   <= 1'b0;
            din_q       <= '0;
            din_last_q  <= 1'b0;
            fifo_wr_q   <= 1'b0;
            enc_dat_q   <= '0;
            dec_addr_q  <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            uncor_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            par_cnt_q   <= par_cnt_d;
            err_cnt_q   <= err_cnt_d;
            eng_start_q <= eng_start_d;
            eng_mode_q  <= eng_mode_d;
            din_vld_q   <= din_vld_d;
            din_q       <= din_d;
            din_last_q  <= din_last_d;
            fifo_wr_q   <= fifo_wr_d;
            enc_dat_q   <= enc_dat_d;
            dec_addr_q  <= dec_addr_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            uncor_q     <= uncor_d;
            timeout_q   <= timeout_d;
        end
    end

    assign eng_start    = eng_start_q;
    assign eng_mode     = eng_mode_q;
    assign eng_din_vld  = din_vld_q;
    assign eng_din      = din_q;
    assign eng_din_last = din_last_q;
    assign ecc_fifo_wr  = fifo_wr_q;
    assign ecc_enc_dat  = enc_dat_q;
    assign ecc_dec_addr = dec_addr_q;
    assign ecc_done     = done_q;
    assign seq_busy     = busy_q;
    assign seq_err_cnt  = err_cnt_q;
    assign seq_uncor    = uncor_q;
    assign seq_timeout  = timeout_q;

endmodule

// File: tb/tb_nfc_ecc_seq.sv
// Directed bench for nfc_ecc_seq: scoreboard queues for engine bytes and bridge writes.
module tb_nfc_ecc_seq;
    import nfc_ecc_pkg::*;

    logic                clk_2x = 1'b0;
    logic                rst_n = 1'b0;
    logic                seq_start = 1'b0, seq_dir = 1'b0, seq_abort = 1'b0;
    logic                nfc_byte_vld = 1'b0;
    logic [ECC_DWID-1:0] nfc_byte = '0;
    logic                eng_start, eng_mode, eng_din_vld, eng_din_last;
    logic [ECC_DWID-1:0] eng_din;
    logic                eng_par_vld = 1'b0;
    logic [ECC_DWID-1:0] eng_par = '0;
    logic                eng_err_vld = 1'b0;
    logic [ECC_AWID-1:0] eng_err_addr = '0;
    logic                eng_dec_done = 1'b0, eng_fail = 1'b0;
    logic                ecc_fifo_wr, ecc_done, seq_busy, seq_uncor, seq_timeout;
    logic [ECC_DWID-1:0] ecc_enc_dat;
    logic [ECC_AWID-1:0] ecc_dec_addr;
    logic [4:0]          seq_err_cnt;

    int        errors = 0;
    int        checks = 0;
    int        done_cnt = 0;
    int        exp_err = 0;
    bit        exp_uncor = 1'b0;
    bit        cur_enc = 1'b0;
    logic [8:0] exp_q[$];
    logic [8:0] din_q[$];
    logic [8:0] mon_exp;

    nfc_ecc_seq u_dut (
        .clk_2x      (clk_2x),
        .rst_n       (rst_n),
        .seq_start   (seq_start),
        .seq_dir     (seq_dir),
        .seq_abort   (seq_abort),
        .nfc_byte_vld(nfc_byte_vld),
        .nfc_byte    (nfc_byte),
        .eng_start   (eng_start),
        .eng_mode    (eng_mode),
        .eng_din_vld (eng_din_vld),
        .eng_din     (eng_din),
        .eng_din_last(eng_din_last),
        .eng_par_vld (eng_par_vld),
        .eng_par     (eng_par),
        .eng_err_vld (eng_err_vld),
        .eng_err_addr(eng_err_addr),
        .eng_dec_done(eng_dec_done),
        .eng_fail    (eng_fail),
        .ecc_fifo_wr (ecc_fifo_wr),
        .ecc_enc_dat (ecc_enc_dat),
        .ecc_dec_addr(ecc_dec_addr),
        .ecc_done    (ecc_done),
        .seq_busy    (seq_busy),
        .seq_err_cnt (seq_err_cnt),
        .seq_uncor   (seq_uncor),
        .seq_timeout (seq_timeout)
    );

    always #5 clk_2x = ~clk_2x;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_2x);
        #1;
    endtask

    // Output monitor on the falling edge, well away from the active edge.
    always @(negedge clk_2x) begin
        if (rst_n) begin
            if (ecc_done) done_cnt++;
            if (ecc_fifo_wr) begin
                if (exp_q.size() == 0) begin
                    check("fifo_wr_unexpected", {23'd0, cur_enc ? {1'b0, ecc_enc_dat} : ecc_dec_addr},
                          32'hFFFF_FFFF);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("fifo_data", {23'd0, cur_enc ? {1'b0, ecc_enc_dat} : ecc_dec_addr},
                          {23'd0, mon_exp});
                end
            end
            if (eng_din_vld) begin
                if (din_q.size() == 0) begin
                    check("din_unexpected", {23'd0, eng_din_last, eng_din}, 32'hFFFF_FFFF);
                end else begin
                    mon_exp = din_q.pop_front();
                    check("eng_din", {23'd0, eng_din_last, eng_din}, {23'd0, mon_exp});
                end
            end
        end
    end

    task automatic start_sector(input bit enc);
        cur_enc   = enc;
        done_cnt  = 0;
        exp_err   = 0;
        exp_uncor = 1'b0;
        seq_start = 1'b1;
        seq_dir   = enc;
        step();
        seq_start = 1'b0;
        check("eng_start", {31'd0, eng_start}, 32'd1);
        check("eng_mode", {31'd0, eng_mode}, {31'd0, enc});
        check("busy_start", {31'd0, seq_busy}, 32'd1);
        check("status_clr", {25'd0, seq_err_cnt, seq_uncor, seq_timeout}, 32'd0);
        step();
        check("eng_start_pulse", {31'd0, eng_start}, 32'd0);
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            nfc_byte_vld = 1'b1;
            nfc_byte     = 8'($urandom);
            din_q.push_back({(i == SECT_LEN - 1), nfc_byte});
            step();
        end
        nfc_byte_vld = 1'b0;
    endtask

    task automatic send_err(input logic [ECC_AWID-1:0] addr, input bit with_done);
        eng_err_vld  = 1'b1;
        eng_err_addr = addr;
        eng_dec_done = with_done;
        if (exp_err < MAX_ERR) begin
            exp_q.push_back(addr);
            exp_err++;
        end else begin
            exp_uncor = 1'b1;
        end
        step();
        eng_err_vld  = 1'b0;
        eng_dec_done = 1'b0;
    endtask

    task automatic pulse_dec_done();
        eng_dec_done = 1'b1;
        step();
        eng_dec_done = 1'b0;
    endtask

    task automatic finish_sector(input string tag, input int exp_cnt, input bit uncor,
                                 input bit tmo, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        step();
        step();
        check({tag, "_done_once"}, done_cnt, 32'd1);
        check({tag, "_writes_left"}, exp_q.size(), 32'd0);
        check({tag, "_din_left"}, din_q.size(), 32'd0);
        check({tag, "_err_cnt"}, {27'd0, seq_err_cnt}, exp_cnt);
        check({tag, "_uncor"}, {31'd0, seq_uncor}, {31'd0, uncor});
        check({tag, "_timeout"}, {31'd0, seq_timeout}, {31'd0, tmo});
        check({tag, "_busy"}, {31'd0, seq_busy}, 32'd0);
    endtask

    initial begin
        int n;
        step();
        step();
        check("rst_mode", {31'd0, eng_mode}, 32'd1);
        check("rst_ctl", {22'd0, eng_start, eng_din_vld, eng_din_last, ecc_fifo_wr, ecc_done,
                          seq_busy, seq_uncor, seq_timeout, 2'd0}, 32'd0);
        check("rst_data", {7'd0, eng_din, ecc_enc_dat, ecc_dec_addr}, 32'd0);
        check("rst_err_cnt", {27'd0, seq_err_cnt}, 32'd0);
        rst_n = 1'b1;
        step();

        // Encode: 512 bytes, 15 parity strobes of which the last is dropped.
        start_sector(1'b1);
        feed(SECT_LEN);
        step();
        for (int i = 0; i < PAR_LEN + 1; i++) begin
            eng_par_vld = 1'b1;
            eng_par     = 8'(i);
            if (i < PAR_LEN) exp_q.push_back(9'(i));
            step();
        end
        eng_par_vld = 1'b0;
        finish_sector("enc", 0, 1'b0, 1'b0, 20);

        // Decode with two separate errors, then done.
        start_sector(1'b0);
        feed(SECT_LEN);
        send_err(9'h005, 1'b0);
        step();
        send_err(9'h1FF, 1'b0);
        pulse_dec_done();
        finish_sector("dec2", 2, 1'b0, 1'b0, 10);

        // Decode with nine errors: the ninth overflows the bridge.
        start_sector(1'b0);
        feed(SECT_LEN);
        for (int i = 0; i < 9; i++) send_err(9'(16 * i + 3), 1'b0);
        pulse_dec_done();
        finish_sector("dec9", MAX_ERR, exp_uncor, 1'b0, 10);

        // Decode: error coincident with dec_done is still written.
        start_sector(1'b0);
        feed(SECT_LEN);
        send_err(9'h0AA, 1'b1);
        finish_sector("decsame", 1, 1'b0, 1'b0, 4);

        // Decode: failure after one error.
        start_sector(1'b0);
        feed(SECT_LEN);
        send_err(9'h033, 1'b0);
        eng_fail = 1'b1;
        step();
        eng_fail = 1'b0;
        finish_sector("fail", 1, 1'b1, 1'b0, 3);

        // Silent engine: timeout exactly TMO_CYC cycles after the last byte.
        start_sector(1'b0);
        feed(SECT_LEN);
        n = 0;
        while (!seq_timeout && n < 1100) begin
            step();
            n++;
        end
        check("timeout_latency", n, TMO_CYC);
        finish_sector("tmo", 0, 1'b0, 1'b1, 10);

        // Abort at byte 100 (coincident byte is not forwarded); start clears old timeout.
        start_sector(1'b1);
        feed(100);
        nfc_byte_vld = 1'b1;
        seq_abort    = 1'b1;
        step();
        seq_abort    = 1'b0;
        finish_sector("abort", 0, 1'b0, 1'b0, 10);
        for (int i = 0; i < 3; i++) step();
        nfc_byte_vld = 1'b0;
        check("idle_bytes_ignored", din_q.size(), 32'd0);

        // Start and abort together in IDLE: no start.
        done_cnt  = 0;
        seq_start = 1'b1;
        seq_abort = 1'b1;
        step();
        seq_start = 1'b0;
        seq_abort = 1'b0;
        check("startabort_eng_start", {31'd0, eng_start}, 32'd0);
        check("startabort_busy", {31'd0, seq_busy}, 32'd0);
        for (int i = 0; i < 5; i++) step();
        check("startabort_no_done", done_cnt, 32'd0);

        // Reset mid-sector: immediate idle, no ecc_done.
        start_sector(1'b0);
        feed(10);
        rst_n = 1'b0;
        #2;
        check("midrst_busy", {31'd0, seq_busy}, 32'd0);
        check("midrst_mode", {31'd0, eng_mode}, 32'd1);
        din_q.delete();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("midrst_no_done", done_cnt, 32'd0);
        check("midrst_idle_busy", {31'd0, seq_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
